// File: rtl/w0rm_alu_divide.sv
`default_nettype none
// ============================================================================
// Module   : w0rm_alu_divide
// Purpose  : Multi-cycle integer divide/remainder unit for the W0RM ALU.
//            Restoring radix-2 divider, one quotient bit per clock, with a
//            sign-fix stage for the signed opcodes. Uses the same
//            request/result handshake as the multiply unit.
// Revision : 1.0 - initial release
// ============================================================================
module w0rm_alu_divide #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  data_valid,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic [3:0]            result_flags
);

  localparam int c_cw = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_cw-1:0]       c_count_init = c_cw'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] c_min_val    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] c_all_ones   = {DATA_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched request
  logic [3:0]            r_opcode;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;

  // Iteration state
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_div;
  logic [c_cw-1:0]       r_count;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_special;

  // Output registers
  logic [DATA_WIDTH-1:0] r_result;
  logic [3:0]            r_flags;
  logic                  r_result_valid;

  // Combinational helpers
  logic                  w_op_ok;
  logic                  w_is_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_WIDTH-1:0] w_a_mag;
  logic [DATA_WIDTH-1:0] w_b_mag;
  logic                  w_div_zero;
  logic                  w_ovf;
  logic [DATA_WIDTH:0]   w_shift;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_diff;
  logic [DATA_WIDTH-1:0] w_fix_q;
  logic [DATA_WIDTH-1:0] w_fix_r;
  logic [DATA_WIDTH-1:0] w_final;

  // Operand conditioning, one divide step and final sign correction
  always_comb begin
    w_op_ok     = (r_opcode[3:2] == 2'b00);
    w_is_signed = (r_opcode == 4'h1) || (r_opcode == 4'h3);
    w_a_neg     = w_is_signed & r_a[DATA_WIDTH-1];
    w_b_neg     = w_is_signed & r_b[DATA_WIDTH-1];
    // Negating MIN wraps back to MIN, which as an unsigned magnitude is exact.
    w_a_mag     = w_a_neg ? (c_min_val ^ c_min_val) - r_a : r_a;
    w_b_mag     = w_b_neg ? (c_min_val ^ c_min_val) - r_b : r_b;
    w_div_zero  = (r_b == '0);
    w_ovf       = w_is_signed && (r_a == c_min_val) && (r_b == c_all_ones);
    // Partial remainder needs one extra bit after the shift; the difference
    // always fits back into DATA_WIDTH bits once the compare succeeds.
    w_shift     = {r_rem, r_quo[DATA_WIDTH-1]};
    w_ge        = (w_shift >= {1'b0, r_div});
    w_diff      = w_shift[DATA_WIDTH-1:0] - r_div;
    w_fix_q     = r_neg_q ? (c_min_val ^ c_min_val) - r_quo : r_quo;
    w_fix_r     = r_neg_r ? (c_min_val ^ c_min_val) - r_rem : r_rem;
    w_final     = r_opcode[1] ? w_fix_r : w_fix_q;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (data_valid) w_state_next = PREP;
      PREP: begin
        if (!w_op_ok) begin
          w_state_next = IDLE;
        end else if (w_div_zero || w_ovf) begin
          w_state_next = FIX;
        end else begin
          w_state_next = DIV;
        end
      end
      DIV:  if (r_count == '0) w_state_next = FIX;
      FIX:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request capture, iteration datapath and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_opcode       <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_div          <= '0;
      r_count        <= '0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
      r_special      <= 1'b0;
      r_result       <= '0;
      r_flags        <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (data_valid) begin
            r_opcode <= opcode;
            r_a      <= data_a;
            r_b      <= data_b;
          end
        end
        PREP: begin
          r_count <= c_count_init;
          r_div   <= w_b_mag;
          if (w_div_zero) begin
            r_special <= 1'b1;
            r_quo     <= c_all_ones;
            r_rem     <= r_a;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
          end else if (w_ovf) begin
            r_special <= 1'b1;
            r_quo     <= c_min_val;
            r_rem     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
          end else begin
            r_special <= 1'b0;
            r_quo     <= w_a_mag;
            r_rem     <= '0;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
          end
        end
        DIV: begin
          r_count <= r_count - c_cw'(1);
          if (w_ge) begin
            r_rem <= w_diff;
            r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[DATA_WIDTH-1:0];
            r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          r_result       <= w_final;
          r_flags        <= {1'b0, r_special, w_final[DATA_WIDTH-1], (w_final == '0)};
          r_result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != IDLE);
  assign result       = r_result;
  assign result_flags = r_flags;
  assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_w0rm_alu_divide.sv
`default_nettype none
// ============================================================================
// Module   : tb_w0rm_alu_divide
// Purpose  : Directed self-checking bench for w0rm_alu_divide (W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_w0rm_alu_divide;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         data_valid = 1'b0;
  logic [3:0]   opcode = 4'h0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;
  logic [3:0]   result_flags;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  w0rm_alu_divide #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_valid   (data_valid),
    .opcode       (opcode),
    .data_a       (data_a),
    .data_b       (data_b),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_flags (result_flags)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge (E0), then scramble the inputs.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    data_valid = 1'b1;
    opcode     = op;
    data_a     = a;
    data_b     = b;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    opcode     = ~op;
    data_a     = ~a;
    data_b     = ~b;
  endtask

  // Edge index (relative to E0) at which result_valid is seen, -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic expect_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int exp_lat,
                           input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
    int lat;
    send(op, a, b);
    wait_valid(lat);
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_res"}, result, exp_res);
    check_val({tag, "_flags"}, result_flags, exp_flags);
    @(posedge clk);
    #1;
    check_val({tag, "_pulse"}, result_valid, 1'b0);
    check_val({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int lat;
    int pulses;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_result", result, 8'h00);
    check_val("rst_valid", result_valid, 1'b0);
    check_val("rst_flags", result_flags, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors
    expect_op("divu_100_7",  4'h0, 8'd100, 8'd7,  10, 8'h0E, 4'b0000);
    expect_op("remu_100_7",  4'h2, 8'd100, 8'd7,  10, 8'h02, 4'b0000);
    expect_op("div_m100_7",  4'h1, 8'h9C,  8'h07, 10, 8'hF2, 4'b0010);
    expect_op("rem_m100_7",  4'h3, 8'h9C,  8'h07, 10, 8'hFE, 4'b0010);
    expect_op("div_100_m7",  4'h1, 8'h64,  8'hF9, 10, 8'hF2, 4'b0010);
    expect_op("divu_by0",    4'h0, 8'h55,  8'h00, 2,  8'hFF, 4'b0110);
    expect_op("remu_by0",    4'h2, 8'h55,  8'h00, 2,  8'h55, 4'b0100);
    expect_op("rem_by0",     4'h3, 8'h9C,  8'h00, 2,  8'h9C, 4'b0110);
    expect_op("div_ovf",     4'h1, 8'h80,  8'hFF, 2,  8'h80, 4'b0110);
    expect_op("divu_3_7",    4'h0, 8'd3,   8'd7,  10, 8'h00, 4'b0001);
    expect_op("div_m128_2",  4'h1, 8'h80,  8'h02, 10, 8'hC0, 4'b0010);

    // data_valid held while busy must be ignored
    @(negedge clk);
    data_valid = 1'b1;
    opcode     = 4'h0;
    data_a     = 8'd100;
    data_b     = 8'd7;
    @(posedge clk);
    #1;
    check_val("hold_busy", busy, 1'b1);
    data_a = 8'd9;
    data_b = 8'd3;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) data_valid = 1'b0;
      if (result_valid) begin
        lat = i;
        break;
      end
    end
    check_val("hold_lat", lat, 10);
    check_val("hold_res", result, 8'h0E);

    // Back-to-back request launched in the result_valid cycle
    data_valid = 1'b1;
    opcode     = 4'h0;
    data_a     = 8'd9;
    data_b     = 8'd3;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    check_val("b2b_busy", busy, 1'b1);
    wait_valid(lat);
    check_val("b2b_lat", lat, 10);
    check_val("b2b_res", result, 8'h03);

    // Asynchronous reset mid-operation
    send(4'h0, 8'd100, 8'd7);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_result", result, 8'h00);
    check_val("arst_valid", result_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) pulses++;
    end
    check_val("arst_nopulse", pulses, 0);
    expect_op("divu_200_10", 4'h0, 8'd200, 8'd10, 10, 8'h14, 4'b0000);

    // Unsupported opcode: one busy cycle, no result
    send(4'h7, 8'h12, 8'h34);
    check_val("badop_busy1", busy, 1'b1);
    @(posedge clk);
    #1;
    check_val("badop_busy0", busy, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) pulses++;
    end
    check_val("badop_nopulse", pulses, 0);
    check_val("badop_result", result, 8'h14);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/w0rm_alu_divide.md
Name: w0rm_alu_divide

Overview:
- Multi-cycle integer divide/remainder unit for the W0RM ALU; the inverse-operation companion to the multiply unit.
- Uses the same request/result interface as the multiply unit (data_valid/opcode/data_a/data_b in; result/result_valid/result_flags out), so the existing FileSource/FileCompare bench structure drives it unchanged.
- Restoring radix-2 divider: one quotient bit per clock, with a sign-fix stage for the signed opcodes.

Parameters:
- DATA_WIDTH, 8, operand and result width in bits (minimum 4).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- data_valid  in  1  request strobe; sampled only when busy=0.
- opcode  in  4  operation select; see Behaviour.
- data_a  in  DATA_WIDTH  dividend.
- data_b  in  DATA_WIDTH  divisor.
- busy  out  1  high while a request is in flight; requests are ignored while high.
- result  out  DATA_WIDTH  quotient or remainder; held until the next result.
- result_valid  out  1  one-cycle pulse marking result/result_flags valid.
- result_flags  out  4  {C,V,N,Z}; C always 0.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, busy=0, result=0, result_valid=0, result_flags=0. Any in-flight operation is discarded and no result_valid is issued for it.
- Opcodes:
  - 4'h0 DIVU: unsigned quotient.
  - 4'h1 DIV: signed quotient, truncated toward zero.
  - 4'h2 REMU: unsigned remainder.
  - 4'h3 REM: signed remainder, carrying the sign of the dividend.
  - Any other opcode is accepted and consumed but produces no result_valid. busy is high for exactly one cycle (E0 to E1), then the unit returns to IDLE.
- busy = (state != IDLE).
- FSM states and transitions:
  - IDLE: on data_valid, latch opcode/a/b, go to PREP (edge E0).
  - PREP: compute operand magnitudes and result sign. If b==0, or (signed op and a==MIN and b==all-ones), go to FIX with the special result. Otherwise load remainder=0, count=DATA_WIDTH-1, go to DIV (E1).
  - DIV: shift {rem,quo} left by 1; trial = rem - |b|; if trial is non-negative, rem=trial and quo LSB=1. Repeat DATA_WIDTH times (E2..E(W+1)), then go to FIX.
  - FIX: apply sign correction, register result and flags, pulse result_valid, go to IDLE (E(W+2)).
- Latency:
  - Normal operation: result_valid is high in the cycle after edge E0+DATA_WIDTH+2.
  - Special cases: result_valid is high after edge E0+2.
  - A new request is accepted on the first edge after result_valid rises; back-to-back issue driven by result_valid is supported.
- Special results:
  - Divide by zero: quotient=all-ones; remainder=data_a unchanged; V=1.
  - Signed overflow (MIN / -1): quotient=MIN, remainder=0, V=1.
- Flags:
  - Z = (result==0).
  - N = result[DATA_WIDTH-1], for all opcodes.
  - V = 1 only in the special cases, otherwise 0.
  - C = 0.
- result_valid is a single-cycle pulse. result and result_flags hold their values after the pulse.
- data_valid asserted while busy=1 has no effect and is not queued.
- Input changes after acceptance do not affect the operation in flight.

Test Plan:
- W=8, DIVU a=100 b=7 -> result 0x0E, flags 4'b0000; result_valid high exactly after edge E0+10. Same operands with REMU -> 0x02.
- DIV a=0x9C (-100) b=0x07 -> 0xF2, flags 4'b0010. REM with same operands -> 0xFE, flags 4'b0010. DIV a=0x64 b=0xF9 -> 0xF2.
- DIVU a=0x55 b=0 -> 0xFF, flags 4'b0110, result_valid after edge E0+2. REMU a=0x55 b=0 -> 0x55, flags 4'b0100.
- DIV a=0x80 b=0xFF -> 0x80, flags 4'b0110. DIVU a=3 b=7 -> 0x00, flags 4'b0001.
- Issue DIVU 100/7, then hold data_valid high for 5 cycles with a=9 b=3 -> only the 0x0E result appears. A request issued in the cycle after result_valid -> result 0x03.
- Drop reset_n low 4 cycles after accept -> busy, result and result_valid go to 0 immediately and no pulse follows. After release, DIVU 200/10 -> 0x14.
- Opcode 4'h7 -> busy high for one cycle, no result_valid, result unchanged.
